pong_game_controller: RTL and testbench

// - Match-level FSM for the Pong game. Produces game_state, which the ball logic consumes.
// - Consumes p1_score/p2_score, which the ball logic produces.
// - Detects points, inserts a serve pause and declares the winner.
// - Issues a one-cycle score_clear pulse so the ball/score logic restarts a match without a global reset.

---
 rtl/pong_game_controller_if.sv | 37 +++
 rtl/pong_game_controller.sv | 222 ++++++++++++++++++++++
 tb/tb_pong_game_controller.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pong_game_controller_if.sv
// ----------------------------------------------------------------------------
// pong_game_controller_if
// Purpose : bundles the signals exchanged between the match-level controller
//           and its environment (timebase, button, ball/score logic).
// Signals :
//   tick_1ms     1 ms strobe, one clk wide
//   start_btn    raw asynchronous start push button, active-high
//   p1_score     player-1 score from ball logic
//   p2_score     player-2 score from ball logic
//   game_state   00 IDLE, 01 PLAY, 10 SERVE, 11 OVER
//   winner       00 none, 01 player 1, 10 player 2
//   score_clear  one-clk pulse telling ball logic to restart the match
//   pause_left   remaining SERVE ticks, 0 outside SERVE
// Modports:
//   master  the controller (drives game_state/winner/score_clear/pause_left)
//   slave   the environment (drives tick, button and scores)
// ----------------------------------------------------------------------------
interface pong_game_controller_if;
    logic       tick_1ms;
    logic       start_btn;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic [1:0] game_state;
    logic [1:0] winner;
    logic       score_clear;
    logic [9:0] pause_left;

    modport master (
        input  tick_1ms, start_btn, p1_score, p2_score,
        output game_state, winner, score_clear, pause_left
    );

    modport slave (
        output tick_1ms, start_btn, p1_score, p2_score,
        input  game_state, winner, score_clear, pause_left
    );
endinterface

// File: rtl/pong_game_controller.sv
// ----------------------------------------------------------------------------
// pong_game_controller
// Purpose : match-level FSM for Pong. Detects points by watching the scores
//           reported by the ball logic, holds a serve pause after each point,
//           declares the winner and issues a one-clk score_clear pulse so a
//           new match starts without a global reset.
// Ports   :
//   clk     system (pixel) clock
//   reset   synchronous, active-high reset
//   bus     pong_game_controller_if.master (tick, button, scores in;
//           game_state, winner, score_clear, pause_left out)
// Parameters:
//   WIN_SCORE    score that ends the match (1..15)
//   PAUSE_MS     tick_1ms pulses spent in SERVE after each point (1..1023)
//   DEBOUNCE_MS  button stable time in ticks (only with START_DEBOUNCE_EN)
// Configuration macro:
//   START_DEBOUNCE_EN  when defined, the synchronized button must be stable
//                      for DEBOUNCE_MS ticks before its level is accepted.
//                      When undefined, the raw synchronized level is used.
// ----------------------------------------------------------------------------
module pong_game_controller #(
    parameter logic [3:0]  WIN_SCORE   = 4'd9,
    parameter int unsigned PAUSE_MS    = 500
`ifdef START_DEBOUNCE_EN
    ,
    parameter int unsigned DEBOUNCE_MS = 20
`endif
) (
    input  logic                          clk,
    input  logic                          reset,
    pong_game_controller_if.master        bus
);

    localparam logic [9:0] PAUSE_LOAD = 10'(PAUSE_MS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_SERVE = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    // ------------------------------------------------------------------
    // Start button: 2-flop synchronizer, optional debounce, edge detect
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_sync_vld;    // r_sync1 holds a real button sample (not reset value)
    logic r_armed;       // button has been seen released since reset
    logic r_level_prev;
    logic w_level;
    logic w_start_pulse;

    // A button held through reset must not look like a fresh press once the
    // synchronizer fills, so edges only count after a released sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1      <= 1'b0;
            r_sync2      <= 1'b0;
            r_sync_vld   <= 1'b0;
            r_armed      <= 1'b0;
            r_level_prev <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the
            // pre-edge value of its source, which is what builds the chain.
            r_sync1      <= bus.start_btn;
            r_sync2      <= r_sync1;
            r_sync_vld   <= 1'b1;
            r_level_prev <= w_level;
            if (r_sync_vld && !r_sync1) begin
                r_armed <= 1'b1;
            end
        end
    end

`ifdef START_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_MS + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);

    logic [DB_W-1:0] r_db_cnt;
    logic            r_db_level;

    // Count consecutive ticks on which the synchronized level differs from
    // the accepted level; any return to the accepted level restarts the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_db_cnt   <= '0;
            r_db_level <= 1'b0;
        end else if (r_sync2 == r_db_level) begin
            r_db_cnt <= '0;
        end else if (bus.tick_1ms) begin
            if (r_db_cnt == DB_LAST) begin
                r_db_level <= r_sync2;
                r_db_cnt   <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_level = r_db_level;
`else
    assign w_level = r_sync2;
`endif

    assign w_start_pulse = w_level & ~r_level_prev & r_armed;

    // ------------------------------------------------------------------
    // Match FSM
    // ------------------------------------------------------------------
    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_winner;
    logic [1:0] w_winner_nxt;
    logic [9:0] r_pause;
    logic [9:0] w_pause_nxt;
    logic [3:0] r_snap_p1;
    logic [3:0] r_snap_p2;
    logic [3:0] w_snap_p1_nxt;
    logic [3:0] w_snap_p2_nxt;
    logic       w_score_clear;
    logic       w_point;

    // Any difference from the snapshot is a point, including decreases and
    // wraps; a simultaneous change of both scores is still a single point.
    assign w_point = ({bus.p1_score, bus.p2_score} != {r_snap_p1, r_snap_p2});

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a variable unassigned, which would infer a latch.
        w_state_nxt   = r_state;
        w_winner_nxt  = r_winner;
        w_pause_nxt   = r_pause;
        w_snap_p1_nxt = r_snap_p1;
        w_snap_p2_nxt = r_snap_p2;
        w_score_clear = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_pause_nxt = '0;
                if (w_start_pulse) begin
                    w_score_clear = 1'b1;
                    w_snap_p1_nxt = '0;
                    w_snap_p2_nxt = '0;
                    w_winner_nxt  = 2'b00;
                    w_pause_nxt   = PAUSE_LOAD;
                    w_state_nxt   = ST_SERVE;
                end
            end

            ST_SERVE: begin
                // start_pulse is deliberately ignored here.
                if (bus.tick_1ms) begin
                    if (r_pause <= 10'd1) begin
                        w_pause_nxt = '0;
                        w_state_nxt = ST_PLAY;
                    end else begin
                        w_pause_nxt = r_pause - 10'd1;
                    end
                end
            end

            ST_PLAY: begin
                w_pause_nxt = '0;
                if (w_point) begin
                    w_snap_p1_nxt = bus.p1_score;
                    w_snap_p2_nxt = bus.p2_score;
                    // Player 1 is checked first so it wins a simultaneous finish.
                    if (bus.p1_score >= WIN_SCORE) begin
                        w_winner_nxt = 2'b01;
                        w_state_nxt  = ST_OVER;
                    end else if (bus.p2_score >= WIN_SCORE) begin
                        w_winner_nxt = 2'b10;
                        w_state_nxt  = ST_OVER;
                    end else begin
                        w_pause_nxt = PAUSE_LOAD;
                        w_state_nxt = ST_SERVE;
                    end
                end
            end

            ST_OVER: begin
                w_pause_nxt = '0;
                if (w_start_pulse) begin
                    w_score_clear = 1'b1;
                    w_winner_nxt  = 2'b00;
                    w_state_nxt   = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_winner_nxt = 2'b00;
                w_pause_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_winner  <= 2'b00;
            r_pause   <= '0;
            // NOTE: the score snapshot is reset rather than left to power-up
            // value because the first PLAY comparison depends on it.
            r_snap_p1 <= '0;
            r_snap_p2 <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_winner  <= w_winner_nxt;
            r_pause   <= w_pause_nxt;
            r_snap_p1 <= w_snap_p1_nxt;
            r_snap_p2 <= w_snap_p2_nxt;
        end
    end

    assign bus.game_state  = r_state;
    assign bus.winner      = r_winner;
    assign bus.pause_left  = r_pause;
    assign bus.score_clear = w_score_clear;

endmodule

// File: tb/tb_pong_game_controller.sv
// ----------------------------------------------------------------------------
// tb_pong_game_controller
// Directed bench for pong_game_controller (WIN_SCORE=9, PAUSE_MS=500).
// Outputs are observed 1 ns after each rising edge as one packed vector
// {game_state, winner, score_clear, pause_left}.
// ----------------------------------------------------------------------------
module tb_pong_game_controller;

    logic clk = 1'b0;
    logic reset;

    pong_game_controller_if bus();

    pong_game_controller #(
        .WIN_SCORE (4'd9),
        .PAUSE_MS  (500)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [14:0] exp_v;

    function automatic logic [14:0] obs();
        return {bus.game_state, bus.winner, bus.score_clear, bus.pause_left};
    endfunction

    function automatic string show(logic [14:0] v);
        return $sformatf("st=%b win=%b clr=%b pause=%0d", v[14:13], v[12:11], v[10], v[9:0]);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic serve_ticks(input int n);
        repeat (n) begin
            bus.tick_1ms = 1'b1;
            step();
        end
        bus.tick_1ms = 1'b0;
    endtask

    // Clean press and release; leaves the button low and synchronized low.
    task automatic press_start();
        bus.start_btn = 1'b1;
        step(); step(); step();
        bus.start_btn = 1'b0;
        step(); step();
    endtask

    task automatic test_reset();
        bus.tick_1ms = 1'b0; bus.start_btn = 1'b0;
        bus.p1_score = 4'd0; bus.p2_score = 4'd0;
        reset = 1'b1;
        step(); step(); step();
        exp_v = {2'b00, 2'b00, 1'b0, 10'd0};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL reset_state: got %s want %s", show(obs()), show(exp_v)); end
        reset = 1'b0;
        step(); step(); step();
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL idle_hold: got %s want %s", show(obs()), show(exp_v)); end
    endtask

    task automatic test_start();
        bus.start_btn = 1'b1;
        step();
        exp_v = {2'b00, 2'b00, 1'b0, 10'd0};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL pre_pulse: got %s want %s", show(obs()), show(exp_v)); end
        step();
        exp_v = {2'b00, 2'b00, 1'b1, 10'd0};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL start_clear: got %s want %s", show(obs()), show(exp_v)); end
        step();
        exp_v = {2'b10, 2'b00, 1'b0, 10'd500};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL enter_serve: got %s want %s", show(obs()), show(exp_v)); end
        bus.start_btn = 1'b0;
        step();
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL serve_no_tick: got %s want %s", show(obs()), show(exp_v)); end
        serve_ticks(1);
        exp_v = {2'b10, 2'b00, 1'b0, 10'd499};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL serve_first_tick: got %s want %s", show(obs()), show(exp_v)); end
        serve_ticks(498);
        exp_v = {2'b10, 2'b00, 1'b0, 10'd1};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL serve_last: got %s want %s", show(obs()), show(exp_v)); end
        serve_ticks(1);
        exp_v = {2'b01, 2'b00, 1'b0, 10'd0};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL serve_to_play: got %s want %s", show(obs()), show(exp_v)); end
    endtask

    task automatic test_point();
        bus.p1_score = 4'd1;
        step();
        exp_v = {2'b10, 2'b00, 1'b0, 10'd500};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL p1_point: got %s want %s", show(obs()), show(exp_v)); end
        serve_ticks(500);
        exp_v = {2'b01, 2'b00, 1'b0, 10'd0};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL p1_point_resume: got %s want %s", show(obs()), show(exp_v)); end
        step();
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL no_change_hold: got %s want %s", show(obs()), show(exp_v)); end
        bus.p1_score = 4'd0;
        step();
        exp_v = {2'b10, 2'b00, 1'b0, 10'd500};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL decrease_point: got %s want %s", show(obs()), show(exp_v)); end
        serve_ticks(500);
    endtask

    task automatic test_p2_win();
        bus.p2_score = 4'd8;
        step();
        exp_v = {2'b10, 2'b00, 1'b0, 10'd500};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL p2_to_8: got %s want %s", show(obs()), show(exp_v)); end
        serve_ticks(500);
        bus.p2_score = 4'd9;
        step();
        exp_v = {2'b11, 2'b10, 1'b0, 10'd0};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL p2_win: got %s want %s", show(obs()), show(exp_v)); end
        step();
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL over_hold: got %s want %s", show(obs()), show(exp_v)); end
        bus.start_btn = 1'b1;
        step(); step();
        exp_v = {2'b11, 2'b10, 1'b1, 10'd0};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL over_clear: got %s want %s", show(obs()), show(exp_v)); end
        bus.p1_score = 4'd0; bus.p2_score = 4'd0;
        step();
        exp_v = {2'b00, 2'b00, 1'b0, 10'd0};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL over_to_idle: got %s want %s", show(obs()), show(exp_v)); end
        bus.start_btn = 1'b0;
        step(); step(); step();
    endtask

    task automatic test_both_win();
        press_start();
        serve_ticks(500);
        bus.p1_score = 4'd8; bus.p2_score = 4'd8;
        step();
        exp_v = {2'b10, 2'b00, 1'b0, 10'd500};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL both_to_8: got %s want %s", show(obs()), show(exp_v)); end
        serve_ticks(500);
        bus.p1_score = 4'd9; bus.p2_score = 4'd9;
        step();
        exp_v = {2'b11, 2'b01, 1'b0, 10'd0};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL both_win_p1: got %s want %s", show(obs()), show(exp_v)); end
    endtask

    task automatic test_serve_ignores_start();
        press_start();
        bus.p1_score = 4'd0; bus.p2_score = 4'd0;
        press_start();
        serve_ticks(10);
        bus.start_btn = 1'b1;
        step(); step();
        exp_v = {2'b10, 2'b00, 1'b0, 10'd490};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL serve_ignores_start: got %s want %s", show(obs()), show(exp_v)); end
        serve_ticks(1);
        exp_v = {2'b10, 2'b00, 1'b0, 10'd489};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL tick_with_pulse: got %s want %s", show(obs()), show(exp_v)); end
        bus.start_btn = 1'b0;
        step(); step();
    endtask

    task automatic test_reset_mid_serve();
        serve_ticks(289);
        exp_v = {2'b10, 2'b00, 1'b0, 10'd200};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL pause_200: got %s want %s", show(obs()), show(exp_v)); end
        reset = 1'b1;
        step();
        exp_v = {2'b00, 2'b00, 1'b0, 10'd0};
        n_cmp++;
        if (obs() !== exp_v) begin n_bad++; $display("FAIL reset_mid_serve: got %s want %s", show(obs()), show(exp_v)); end
        reset = 1'b0;
    endtask

    task automatic test_held_through_reset();
        int seen;
        bus.start_btn = 1'b1;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        seen = 0;
        repeat (8) begin step(); if (bus.score_clear === 1'b1) seen++; end
        n_cmp++;
        if (seen != 0 || bus.game_state !== 2'b00) begin
            n_bad++; $display("FAIL held_no_pulse: got pulses=%0d st=%b want pulses=0 st=00", seen, bus.game_state);
        end
        bus.start_btn = 1'b0;
        step(); step(); step();
        bus.start_btn = 1'b1;
        seen = 0;
        repeat (4) begin step(); if (bus.score_clear === 1'b1) seen++; end
        n_cmp++;
        if (seen != 1 || bus.game_state !== 2'b10) begin
            n_bad++; $display("FAIL repress_pulse: got pulses=%0d st=%b want pulses=1 st=10", seen, bus.game_state);
        end
        bus.start_btn = 1'b0;
        step(); step();
    endtask

`ifdef START_DEBOUNCE_EN
    task automatic test_debounce();
        int seen;
        seen = 0;
        bus.tick_1ms = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.start_btn = ~bus.start_btn;
            repeat (3) begin step(); if (bus.score_clear === 1'b1) seen++; end
        end
        n_cmp++;
        if (seen != 0) begin n_bad++; $display("FAIL bounce_quiet: got pulses=%0d want 0", seen); end
        bus.start_btn = 1'b1;
        repeat (25) begin step(); if (bus.score_clear === 1'b1) seen++; end
        bus.tick_1ms = 1'b0;
        n_cmp++;
        if (seen != 1) begin n_bad++; $display("FAIL debounce_one_pulse: got pulses=%0d want 1", seen); end
        n_cmp++;
        if (bus.game_state !== 2'b10) begin n_bad++; $display("FAIL debounce_serve: got st=%b want 10", bus.game_state); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        test_reset();
`ifdef START_DEBOUNCE_EN
        test_debounce();
`else
        test_start();
        test_point();
        test_p2_win();
        test_both_win();
        test_serve_ignores_start();
        test_reset_mid_serve();
        test_held_through_reset();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
